// File: rtl/pwm_pkg.sv
// pwm_pkg: state encoding and counter constants shared by the PWM capture path.
package pwm_pkg;

    localparam int CNT_W_DEF = 16;
    localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

endpackage

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: PWM input pin plus measurement results.
interface pwm_capture_if
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);

    logic             pulse_in;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             meas_valid;
    logic             stuck;

    modport master (
        output pulse_in,
        input  high_cnt,
        input  period_cnt,
        input  meas_valid,
        input  stuck
    );

    modport slave (
        input  pulse_in,
        output high_cnt,
        output period_cnt,
        output meas_valid,
        output stuck
    );

endinterface

// File: rtl/pwm_in_cond.sv
// pwm_in_cond: synchronizer, optional deglitch filter (PWM_DEGLITCH_EN), edge detect.
module pwm_in_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int DGL_LEN     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_s,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_filt;
    logic                   r_s_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
        end
    end

`ifdef PWM_DEGLITCH_EN
    localparam int L_DW = $clog2(DGL_LEN + 1);

    logic            r_filt;
    logic [L_DW-1:0] r_dcnt;

    // Counter runs only while the input disagrees with the filtered level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt <= 1'b0;
            r_dcnt <= '0;
        end else if (r_sync[SYNC_STAGES-1] == r_filt) begin
            r_dcnt <= '0;
        end else if (r_dcnt == L_DW'(DGL_LEN - 1)) begin
            r_filt <= r_sync[SYNC_STAGES-1];
            r_dcnt <= '0;
        end else begin
            r_dcnt <= r_dcnt + 1'b1;
        end
    end

    assign w_filt = r_filt;
`else
    assign w_filt = r_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_d <= 1'b0;
        end else begin
            r_s_d <= w_filt;
        end
    end

    assign o_s    = w_filt;
    assign o_rise = w_filt & ~r_s_d;
    assign o_fall = ~w_filt & r_s_d;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of a PWM input, flags a stuck input.
// Define PWM_DEGLITCH_EN to insert a DGL_LEN-cycle stability filter on the input.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int DGL_LEN     = 4
) (
    input logic          clk,
    input logic          rst,
    pwm_capture_if.slave bus
);

    localparam logic [CNT_W-1:0] L_MAX = '1;
    localparam logic [CNT_W-1:0] L_ONE = CNT_W'(1);

    logic w_s;
    logic w_rise;
    logic w_fall_unused;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_per, w_per_nxt;
    logic [CNT_W-1:0] r_hi, w_hi_nxt;
    logic [CNT_W-1:0] r_high, w_high_nxt;
    logic [CNT_W-1:0] r_period, w_period_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_stuck, w_stuck_nxt;

    pwm_in_cond #(
        .SYNC_STAGES (SYNC_STAGES),
        .DGL_LEN     (DGL_LEN)
    ) u_cond (
        .clk    (clk),
        .rst    (rst),
        .i_din  (bus.pulse_in),
        .o_s    (w_s),
        .o_rise (w_rise),
        .o_fall (w_fall_unused)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_per    <= '0;
            r_hi     <= '0;
            r_high   <= '0;
            r_period <= '0;
            r_valid  <= 1'b0;
            r_stuck  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_per    <= w_per_nxt;
            r_hi     <= w_hi_nxt;
            r_high   <= w_high_nxt;
            r_period <= w_period_nxt;
            r_valid  <= w_valid_nxt;
            r_stuck  <= w_stuck_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_per_nxt    = r_per;
        w_hi_nxt     = r_hi;
        w_high_nxt   = r_high;
        w_period_nxt = r_period;
        w_valid_nxt  = 1'b0;
        w_stuck_nxt  = r_stuck;
        unique case (r_state)
            IDLE: begin
                w_per_nxt = '0;
                w_hi_nxt  = '0;
                if (w_rise) begin
                    w_per_nxt   = L_ONE;
                    w_hi_nxt    = L_ONE;
                    w_state_nxt = ARMED;
                end
            end
            ARMED: begin
                // A rise on the saturating cycle is still a valid measurement.
                if (w_rise) begin
                    w_period_nxt = r_per;
                    w_high_nxt   = r_hi;
                    w_valid_nxt  = 1'b1;
                    w_stuck_nxt  = 1'b0;
                    w_per_nxt    = L_ONE;
                    w_hi_nxt     = L_ONE;
                end else if (r_per == L_MAX) begin
                    w_stuck_nxt  = 1'b1;
                    w_per_nxt    = '0;
                    w_hi_nxt     = '0;
                    w_state_nxt  = IDLE;
                end else begin
                    w_per_nxt = r_per + L_ONE;
                    w_hi_nxt  = r_hi + {{(CNT_W-1){1'b0}}, w_s};
                end
            end
        endcase
    end

    assign bus.high_cnt   = r_high;
    assign bus.period_cnt = r_period;
    assign bus.meas_valid = r_valid;
    assign bus.stuck      = r_stuck;

endmodule
